// File: rtl/axi_pc_pkg.sv
// Shared constants for the AXI write-burst protocol checker.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package axi_pc_pkg;

  // Width of the sticky status vector, one bit per check
  localparam int STATUS_W = 9;

  // Check indices into pc_status
  localparam int CHK_AW_STABLE     = 0;
  localparam int CHK_W_STABLE      = 1;
  localparam int CHK_B_STABLE      = 2;
  localparam int CHK_WLAST_EARLY   = 3;
  localparam int CHK_WLAST_MISSING = 4;
  localparam int CHK_W_NO_AW       = 5;
  localparam int CHK_AW_OVERFLOW   = 6;
  localparam int CHK_BURST_ILLEGAL = 7;
  localparam int CHK_B_UNEXPECTED  = 8;

  // AXI AWBURST encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  // Index of the lowest set bit (0 when nothing is set)
  function automatic logic [3:0] lowest_idx(input logic [STATUS_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = STATUS_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Number of set bits in a status vector
  function automatic logic [3:0] count_ones(input logic [STATUS_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < STATUS_W; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_pc_len_fifo.sv
// Burst-length FIFO: holds AWLEN of accepted bursts awaiting their W data.
// Latency: push visible at head on the next cycle; head is combinational read.
// Backpressure: none; push is ignored when full unless a pop occurs in the same cycle.
module axi_pc_len_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  // Extra pointer bit distinguishes full from empty
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_dout  = r_mem[r_rd_ptr[PW-1:0]];

  // Pointer advance on accepted push/pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate every read
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/axi_wr_burst_checker.sv
// Passive AXI write-channel protocol checker with sticky status and error count.
// Latency: violations appear on the outputs one cycle after the offending edge.
// Backpressure: none; observes the bus only and never stalls it.
module axi_wr_burst_checker
  import axi_pc_pkg::*;
#(
  parameter int                  ADDR_W     = 64,
  parameter int                  DATA_W     = 512,
  parameter int                  MAX_OUT    = 8,
  parameter logic [STATUS_W-1:0] CHECK_MASK = 9'h1FF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  pc_clear,
  input  logic [ADDR_W-1:0]     pc_axi_awaddr,
  input  logic [7:0]            pc_axi_awlen,
  input  logic [2:0]            pc_axi_awsize,
  input  logic [1:0]            pc_axi_awburst,
  input  logic                  pc_axi_awvalid,
  input  logic                  pc_axi_awready,
  input  logic [DATA_W-1:0]     pc_axi_wdata,
  input  logic [DATA_W/8-1:0]   pc_axi_wstrb,
  input  logic                  pc_axi_wlast,
  input  logic                  pc_axi_wvalid,
  input  logic                  pc_axi_wready,
  input  logic [1:0]            pc_axi_bresp,
  input  logic                  pc_axi_bvalid,
  input  logic                  pc_axi_bready,
  output logic [STATUS_W-1:0]   pc_status,
  output logic                  pc_asserted,
  output logic [4:0]            pc_first_err,
  output logic [15:0]           pc_err_cnt
);

  localparam int         CW         = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUT);
  localparam logic [2:0] SIZE_MAX   = 3'($clog2(DATA_W / 8));

  // Stability history: previous-cycle stall flag and payload per channel
  logic                r_aw_hold;
  logic [ADDR_W-1:0]   r_awaddr_q;
  logic [7:0]          r_awlen_q;
  logic [2:0]          r_awsize_q;
  logic [1:0]          r_awburst_q;
  logic                r_w_hold;
  logic [DATA_W-1:0]   r_wdata_q;
  logic [DATA_W/8-1:0] r_wstrb_q;
  logic                r_wlast_q;
  logic                r_b_hold;
  logic [1:0]          r_bresp_q;

  // Burst tracking
  logic [7:0]          r_beat_cnt;
  logic [CW-1:0]       r_credit;

  // Registered outputs
  logic [STATUS_W-1:0] r_status;
  logic                r_asserted;
  logic [4:0]          r_first_err;
  logic [15:0]         r_err_cnt;

  // Handshakes and FIFO interface
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [7:0]          w_fifo_dout;
  logic                w_fifo_push;
  logic                w_fifo_pop;
  logic [7:0]          w_head_len;
  logic                w_has_burst;
  logic                w_beat_ok;
  logic                w_at_len;
  logic                w_complete;
  logic                w_credit_dec;

  // Violation and next-state terms
  logic [STATUS_W-1:0] w_viol;
  logic [STATUS_W-1:0] w_viol_en;
  logic [STATUS_W-1:0] w_status_nxt;
  logic [15:0]         w_cnt_base;
  logic [16:0]         w_cnt_sum;
  logic [15:0]         w_cnt_nxt;

  assign w_aw_hs = pc_axi_awvalid && pc_axi_awready;
  assign w_w_hs  = pc_axi_wvalid  && pc_axi_wready;
  assign w_b_hs  = pc_axi_bvalid  && pc_axi_bready;

  // A W beat belongs to the FIFO head, or to the AW arriving this cycle when the FIFO is empty
  assign w_has_burst = !w_fifo_empty || w_aw_hs;
  assign w_head_len  = w_fifo_empty ? pc_axi_awlen : w_fifo_dout;
  assign w_beat_ok   = w_w_hs && w_has_burst;
  assign w_at_len    = (r_beat_cnt == w_head_len);
  assign w_complete  = w_beat_ok && (pc_axi_wlast || w_at_len);

  // Empty FIFO with a same-cycle push and completing beat: the burst bypasses storage
  assign w_fifo_pop  = w_complete && !w_fifo_empty;
  assign w_fifo_push = w_aw_hs && !(w_fifo_full && !w_fifo_pop) &&
                       !(w_fifo_empty && w_complete);

  assign w_credit_dec = w_b_hs && (r_credit != '0);

  axi_pc_len_fifo #(
    .WIDTH (8),
    .DEPTH (MAX_OUT)
  ) u_len_fifo (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_push  (w_fifo_push),
    .i_din   (pc_axi_awlen),
    .i_pop   (w_fifo_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Per-check violation detection for the current cycle
  always_comb begin
    w_viol = '0;
    w_viol[CHK_AW_STABLE] = r_aw_hold &&
        (!pc_axi_awvalid || (pc_axi_awaddr != r_awaddr_q) ||
         (pc_axi_awlen != r_awlen_q) || (pc_axi_awsize != r_awsize_q) ||
         (pc_axi_awburst != r_awburst_q));
    w_viol[CHK_W_STABLE] = r_w_hold &&
        (!pc_axi_wvalid || (pc_axi_wdata != r_wdata_q) ||
         (pc_axi_wstrb != r_wstrb_q) || (pc_axi_wlast != r_wlast_q));
    w_viol[CHK_B_STABLE] = r_b_hold &&
        (!pc_axi_bvalid || (pc_axi_bresp != r_bresp_q));
    w_viol[CHK_WLAST_EARLY]   = w_beat_ok && pc_axi_wlast && (r_beat_cnt < w_head_len);
    w_viol[CHK_WLAST_MISSING] = w_beat_ok && !pc_axi_wlast && w_at_len;
    w_viol[CHK_W_NO_AW]       = w_w_hs && w_fifo_empty && !w_aw_hs;
    w_viol[CHK_AW_OVERFLOW]   = w_aw_hs && w_fifo_full && !w_fifo_pop;
    w_viol[CHK_BURST_ILLEGAL] = w_aw_hs &&
        ((pc_axi_awburst == BURST_RSVD) ||
         ((pc_axi_awburst == BURST_WRAP) &&
          !(pc_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
         (pc_axi_awsize > SIZE_MAX));
    w_viol[CHK_B_UNEXPECTED]  = w_b_hs && (r_credit == '0);
  end

  // Masked violations merged with sticky state; new violations win over clear
  always_comb begin
    w_viol_en    = w_viol & CHECK_MASK;
    w_status_nxt = (pc_clear ? '0 : r_status) | w_viol_en;
    w_cnt_base   = pc_clear ? 16'h0000 : r_err_cnt;
    w_cnt_sum    = {1'b0, w_cnt_base} + {13'b0, count_ones(w_viol_en)};
    w_cnt_nxt    = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end

  // Capture handshake-stall state and payload for next-cycle stability compare
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_hold   <= 1'b0;
      r_awaddr_q  <= '0;
      r_awlen_q   <= '0;
      r_awsize_q  <= '0;
      r_awburst_q <= '0;
      r_w_hold    <= 1'b0;
      r_wdata_q   <= '0;
      r_wstrb_q   <= '0;
      r_wlast_q   <= 1'b0;
      r_b_hold    <= 1'b0;
      r_bresp_q   <= '0;
    end else begin
      r_aw_hold   <= pc_axi_awvalid && !pc_axi_awready;
      r_awaddr_q  <= pc_axi_awaddr;
      r_awlen_q   <= pc_axi_awlen;
      r_awsize_q  <= pc_axi_awsize;
      r_awburst_q <= pc_axi_awburst;
      r_w_hold    <= pc_axi_wvalid && !pc_axi_wready;
      r_wdata_q   <= pc_axi_wdata;
      r_wstrb_q   <= pc_axi_wstrb;
      r_wlast_q   <= pc_axi_wlast;
      r_b_hold    <= pc_axi_bvalid && !pc_axi_bready;
      r_bresp_q   <= pc_axi_bresp;
    end
  end

  // Beat counter: advances on tracked beats, returns to 0 when a burst completes
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat_cnt <= '0;
    end else if (w_beat_ok) begin
      r_beat_cnt <= w_complete ? 8'd0 : r_beat_cnt + 8'd1;
    end
  end

  // Pending-B credit: +1 per completed burst, -1 per legal B, clamped to [0, MAX_OUT]
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_credit <= '0;
    end else begin
      case ({w_complete, w_credit_dec})
        2'b10:   if (r_credit != CREDIT_MAX) r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Registered status, first-error latch and saturating error count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_status    <= '0;
      r_asserted  <= 1'b0;
      r_first_err <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_status   <= w_status_nxt;
      r_asserted <= |w_status_nxt;
      r_err_cnt  <= w_cnt_nxt;
      if (pc_clear || !r_first_err[4]) begin
        r_first_err <= (|w_viol_en) ? {1'b1, lowest_idx(w_viol_en)} : 5'h00;
      end
    end
  end

  assign pc_status    = r_status;
  assign pc_asserted  = r_asserted;
  assign pc_first_err = r_first_err;
  assign pc_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_axi_wr_burst_checker.sv
// Directed self-checking bench for axi_wr_burst_checker.
// Latency: outputs are sampled 1 ns after the edge that registers a violation.
// Backpressure: readys are driven by the bench to create stall scenarios.
module tb_axi_wr_burst_checker;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          pc_clear;
  logic [63:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [511:0]  wdata;
  logic [63:0]   wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [8:0]    pc_status;
  logic          pc_asserted;
  logic [4:0]    pc_first_err;
  logic [15:0]   pc_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_wr_burst_checker dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .pc_clear       (pc_clear),
    .pc_axi_awaddr  (awaddr),
    .pc_axi_awlen   (awlen),
    .pc_axi_awsize  (awsize),
    .pc_axi_awburst (awburst),
    .pc_axi_awvalid (awvalid),
    .pc_axi_awready (awready),
    .pc_axi_wdata   (wdata),
    .pc_axi_wstrb   (wstrb),
    .pc_axi_wlast   (wlast),
    .pc_axi_wvalid  (wvalid),
    .pc_axi_wready  (wready),
    .pc_axi_bresp   (bresp),
    .pc_axi_bvalid  (bvalid),
    .pc_axi_bready  (bready),
    .pc_status      (pc_status),
    .pc_asserted    (pc_asserted),
    .pc_first_err   (pc_first_err),
    .pc_err_cnt     (pc_err_cnt)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    pc_clear = 1'b0;
    awvalid = 1'b0; awready = 1'b1; awaddr = '0; awlen = '0;
    awsize = 3'd6; awburst = 2'b01;
    wvalid = 1'b0; wready = 1'b1; wdata = '0; wstrb = '1; wlast = 1'b0;
    bvalid = 1'b0; bready = 1'b1; bresp = 2'b00;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle();
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic aw_hs(input logic [7:0] len, input logic [1:0] burst);
    awvalid = 1'b1; awlen = len; awburst = burst;
    step();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic last);
    wvalid = 1'b1; wlast = last; wdata = wdata + 512'd1;
    step();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_hs();
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    idle();
    step();
    step();
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL reset_status got %h exp %h", pc_status, 9'h000); end
    checks++; if (pc_asserted !== 1'b0) begin errors++; $display("FAIL reset_asserted got %b exp 0", pc_asserted); end
    checks++; if (pc_first_err !== 5'h00) begin errors++; $display("FAIL reset_first_err got %h exp 00", pc_first_err); end
    checks++; if (pc_err_cnt !== 16'h0000) begin errors++; $display("FAIL reset_err_cnt got %h exp 0000", pc_err_cnt); end
  endtask

  task automatic test_legal();
    do_reset();
    aw_hs(8'd3, 2'b01);
    w_beat(1'b0); w_beat(1'b0); w_beat(1'b0); w_beat(1'b1);
    b_hs();
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL legal_status got %h exp %h", pc_status, 9'h000); end
    checks++; if (pc_err_cnt !== 16'h0000) begin errors++; $display("FAIL legal_err_cnt got %h exp 0000", pc_err_cnt); end
    checks++; if (pc_asserted !== 1'b0) begin errors++; $display("FAIL legal_asserted got %b exp 0", pc_asserted); end
  endtask

  task automatic test_wlast_early();
    do_reset();
    aw_hs(8'd3, 2'b01);
    w_beat(1'b0); w_beat(1'b1);
    checks++; if (pc_status !== 9'h008) begin errors++; $display("FAIL early_status got %h exp %h", pc_status, 9'h008); end
    checks++; if (pc_first_err !== 5'h13) begin errors++; $display("FAIL early_first_err got %h exp 13", pc_first_err); end
    checks++; if (pc_err_cnt !== 16'd1) begin errors++; $display("FAIL early_err_cnt got %0d exp 1", pc_err_cnt); end
    checks++; if (pc_asserted !== 1'b1) begin errors++; $display("FAIL early_asserted got %b exp 1", pc_asserted); end
    b_hs();
    aw_hs(8'd1, 2'b01);
    w_beat(1'b0); w_beat(1'b1);
    b_hs();
    checks++; if (pc_status !== 9'h008) begin errors++; $display("FAIL early_next_status got %h exp %h", pc_status, 9'h008); end
    checks++; if (pc_err_cnt !== 16'd1) begin errors++; $display("FAIL early_next_err_cnt got %0d exp 1", pc_err_cnt); end
    pc_clear = 1'b1;
    step();
    pc_clear = 1'b0;
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL clear_status got %h exp %h", pc_status, 9'h000); end
    checks++; if (pc_first_err !== 5'h00) begin errors++; $display("FAIL clear_first_err got %h exp 00", pc_first_err); end
    checks++; if (pc_err_cnt !== 16'd0) begin errors++; $display("FAIL clear_err_cnt got %0d exp 0", pc_err_cnt); end
  endtask

  task automatic test_wlast_missing();
    do_reset();
    aw_hs(8'd1, 2'b01);
    w_beat(1'b0); w_beat(1'b0);
    checks++; if (pc_status !== 9'h010) begin errors++; $display("FAIL missing_status got %h exp %h", pc_status, 9'h010); end
    checks++; if (pc_first_err !== 5'h14) begin errors++; $display("FAIL missing_first_err got %h exp 14", pc_first_err); end
    b_hs();
    checks++; if (pc_status !== 9'h010) begin errors++; $display("FAIL missing_b_status got %h exp %h", pc_status, 9'h010); end
    checks++; if (pc_err_cnt !== 16'd1) begin errors++; $display("FAIL missing_b_err_cnt got %0d exp 1", pc_err_cnt); end
  endtask

  task automatic test_aw_stable();
    do_reset();
    awvalid = 1'b1; awready = 1'b0; awaddr = 64'h1000; awlen = 8'd0;
    step();
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL aw_stall_status got %h exp %h", pc_status, 9'h000); end
    awaddr = 64'h1040;
    step();
    checks++; if (pc_status !== 9'h001) begin errors++; $display("FAIL aw_stable_status got %h exp %h", pc_status, 9'h001); end
    checks++; if (pc_first_err !== 5'h10) begin errors++; $display("FAIL aw_stable_first_err got %h exp 10", pc_first_err); end
    awready = 1'b1;
    step();
    awvalid = 1'b0;
    checks++; if (pc_err_cnt !== 16'd1) begin errors++; $display("FAIL aw_stable_err_cnt got %0d exp 1", pc_err_cnt); end
  endtask

  task automatic test_same_cycle_push();
    do_reset();
    awvalid = 1'b1; awlen = 8'd0; wvalid = 1'b1; wlast = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    b_hs();
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL bypass_status got %h exp %h", pc_status, 9'h000); end
    awvalid = 1'b1; awlen = 8'd1; wvalid = 1'b1; wlast = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    w_beat(1'b1);
    b_hs();
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL push_beat_status got %h exp %h", pc_status, 9'h000); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) aw_hs(8'd0, 2'b01);
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL fill_status got %h exp %h", pc_status, 9'h000); end
    aw_hs(8'd5, 2'b10);
    checks++; if (pc_status !== 9'h0C0) begin errors++; $display("FAIL overflow_status got %h exp %h", pc_status, 9'h0C0); end
    checks++; if (pc_first_err !== 5'h16) begin errors++; $display("FAIL overflow_first_err got %h exp 16", pc_first_err); end
    checks++; if (pc_err_cnt !== 16'd2) begin errors++; $display("FAIL overflow_err_cnt got %0d exp 2", pc_err_cnt); end
    do_reset();
    aw_hs(8'd5, 2'b10);
    checks++; if (pc_status !== 9'h080) begin errors++; $display("FAIL wrap5_status got %h exp %h", pc_status, 9'h080); end
    checks++; if (pc_first_err !== 5'h17) begin errors++; $display("FAIL wrap5_first_err got %h exp 17", pc_first_err); end
    do_reset();
    aw_hs(8'd7, 2'b10);
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL wrap7_status got %h exp %h", pc_status, 9'h000); end
    awsize = 3'd7;
    aw_hs(8'd0, 2'b01);
    awsize = 3'd6;
    checks++; if (pc_status !== 9'h080) begin errors++; $display("FAIL size7_status got %h exp %h", pc_status, 9'h080); end
  endtask

  task automatic test_b_unexpected();
    do_reset();
    b_hs();
    checks++; if (pc_status !== 9'h100) begin errors++; $display("FAIL b_unexp_status got %h exp %h", pc_status, 9'h100); end
    checks++; if (pc_first_err !== 5'h18) begin errors++; $display("FAIL b_unexp_first_err got %h exp 18", pc_first_err); end
    do_reset();
    aw_hs(8'd0, 2'b01);
    wvalid = 1'b1; wlast = 1'b1; bvalid = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0; bvalid = 1'b0;
    checks++; if (pc_status !== 9'h100) begin errors++; $display("FAIL b_same_cycle_status got %h exp %h", pc_status, 9'h100); end
    b_hs();
    checks++; if (pc_err_cnt !== 16'd1) begin errors++; $display("FAIL b_credit_err_cnt got %0d exp 1", pc_err_cnt); end
  endtask

  task automatic test_clear_same_cycle();
    do_reset();
    b_hs();
    pc_clear = 1'b1; wvalid = 1'b1; wlast = 1'b1;
    step();
    pc_clear = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    checks++; if (pc_status !== 9'h020) begin errors++; $display("FAIL clr_set_status got %h exp %h", pc_status, 9'h020); end
    checks++; if (pc_err_cnt !== 16'd1) begin errors++; $display("FAIL clr_set_err_cnt got %0d exp 1", pc_err_cnt); end
    checks++; if (pc_first_err !== 5'h15) begin errors++; $display("FAIL clr_set_first_err got %h exp 15", pc_first_err); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    aw_hs(8'd3, 2'b01);
    w_beat(1'b0); w_beat(1'b0);
    awvalid = 1'b1; awready = 1'b0; awaddr = 64'h2000; awlen = 8'd1;
    step();
    aresetn = 1'b0;
    step();
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL mid_rst_status got %h exp %h", pc_status, 9'h000); end
    aresetn = 1'b1; awaddr = 64'h3000;
    step();
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL post_rst_stable got %h exp %h", pc_status, 9'h000); end
    awready = 1'b1;
    step();
    awvalid = 1'b0;
    w_beat(1'b0); w_beat(1'b1);
    b_hs();
    checks++; if (pc_status !== 9'h000) begin errors++; $display("FAIL post_rst_burst got %h exp %h", pc_status, 9'h000); end
    checks++; if (pc_err_cnt !== 16'd0) begin errors++; $display("FAIL post_rst_err_cnt got %0d exp 0", pc_err_cnt); end
  endtask

  initial begin
    aresetn = 1'b0;
    idle();
    test_reset();
    test_legal();
    test_wlast_early();
    test_wlast_missing();
    test_aw_stable();
    test_same_cycle_push();
    test_overflow();
    test_b_unexpected();
    test_clear_same_cycle();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
